fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO. Successor to the memoria storage block.
- Owns its write and read pointers, occupancy count, full/empty flags and programmable almost-full/almost-empty flags; callers no longer drive addresses.
- Sits between the packet-producing stage and the consumer in the datapath.
- Storage is an internal register array of DEPTH = 2**ADDR_WIDTH words.

Parameters:
- DATA_WIDTH, 12, width of each FIFO word.
- ADDR_WIDTH, 8, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- ALMOST_FULL_TH, 3, FIFO_almost_full asserts when free entries <= this value (range 0..DEPTH-1).
- ALMOST_EMPTY_TH, 3, FIFO_almost_empty asserts when occupancy <= this value (range 0..DEPTH-1).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_enable  input  1  push request.
- FIFO_data_in  input  DATA_WIDTH  push data.
- read_enable  input  1  pop request.
- FIFO_data_out  output  DATA_WIDTH  registered pop data.
- FIFO_valid  output  1  FIFO_data_out holds a word popped on the previous edge.
- FIFO_full  output  1  occupancy == DEPTH.
- FIFO_empty  output  1  occupancy == 0.
- FIFO_almost_full  output  1  (DEPTH - occupancy) <= ALMOST_FULL_TH.
- FIFO_almost_empty  output  1  occupancy <= ALMOST_EMPTY_TH.
- FIFO_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (sampled at rising edge while reset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - FIFO_data_out=0, FIFO_valid=0, FIFO_full=0, FIFO_empty=1.
  - FIFO_almost_empty=1. FIFO_almost_full=1 only if ALMOST_FULL_TH >= DEPTH, otherwise 0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all queued data and overrides any simultaneous read or write in that cycle.
- Write accepted when write_enable=1 and (FIFO_full=0 or read accepted in the same cycle):
  - mem[wr_ptr] <= FIFO_data_in; wr_ptr increments modulo DEPTH.
- Read accepted when read_enable=1 and FIFO_empty=0:
  - FIFO_data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; FIFO_valid <= 1.
  - Otherwise FIFO_valid <= 0 and FIFO_data_out holds its previous value.
- Read latency: data appears on FIFO_data_out one clock after the accepting edge.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered and derived from the next-state count, so they are valid in the same cycle as FIFO_count.
- Boundary conditions:
  - Full + write, no read: write dropped, no state change.
  - Full + write + read: both accepted; count stays DEPTH; the oldest word is output.
  - Empty + read, no write: read ignored, FIFO_valid=0.
  - Empty + write + read: write accepted, read ignored; count becomes 1. No fall-through: the new word is readable from the next cycle.
  - Pointer wrap from DEPTH-1 to 0 is seamless; ordering is strictly first-in first-out.
- Pointer arithmetic is ADDR_WIDTH bits with natural overflow. Count is ADDR_WIDTH+1 bits and never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: FIFO_ERROR_FLAGS_EN.
- When defined, two extra outputs exist:
  - FIFO_overflow (1 bit): set on any dropped write (write_enable=1, FIFO_full=1, no accepted read).
  - FIFO_underflow (1 bit): set on any ignored read (read_enable=1, FIFO_empty=1).
  - Both are sticky until reset and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 3 cycles -> FIFO_empty=1, FIFO_almost_empty=1, FIFO_count=0, FIFO_valid=0, FIFO_data_out=0.
- Write 0x001..0x100 (256 words, defaults) -> FIFO_full=1 after 256th edge, FIFO_count=256, FIFO_almost_full rises when count reaches 253; 257th write dropped (FIFO_overflow=1 if FIFO_ERROR_FLAGS_EN).
- Drain the full FIFO -> outputs 0x001..0x100 in order, each one cycle after its read edge with FIFO_valid=1; FIFO_empty=1 after last read; extra read gives FIFO_valid=0 (FIFO_underflow=1 if enabled).
- Wrap test: push 200, pop 200, push 100, pop 100 with data = index -> correct order across pointer wrap; FIFO_count returns to 0.
- Simultaneous read+write when full and when empty -> full: count stays 256, oldest word out; empty: count becomes 1, FIFO_valid=0 that cycle.
- Assert reset with count=50 during simultaneous read+write -> next cycle count=0, FIFO_empty=1, FIFO_valid=0, error flags cleared.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count and full/empty/almost flags.
// Optional sticky overflow/underflow outputs are built when FIFO_ERROR_FLAGS_EN is defined.
module fifo_param #(
   parameter int DATA_WIDTH      = 12,
   parameter int ADDR_WIDTH      = 8,
   parameter int ALMOST_FULL_TH  = 3,
   parameter int ALMOST_EMPTY_TH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] FIFO_data_in,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] FIFO_data_out,
   output logic                  FIFO_valid,
   output logic                  FIFO_full,
   output logic                  FIFO_empty,
   output logic                  FIFO_almost_full,
   output logic                  FIFO_almost_empty,
`ifdef FIFO_ERROR_FLAGS_EN
   output logic                  FIFO_overflow,
   output logic                  FIFO_underflow,
`endif
   output logic [ADDR_WIDTH:0]   FIFO_count
);

   localparam int                DEPTH   = 1 << ADDR_WIDTH;
   localparam int                CW      = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]       AF_TH   = 32'(ALMOST_FULL_TH);
   localparam logic [31:0]       AE_TH   = 32'(ALMOST_EMPTY_TH);
   localparam logic              AF_RST  = (ALMOST_FULL_TH >= DEPTH) ? 1'b1 : 1'b0;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;

   logic                  w_rd_accept;
   logic                  w_wr_accept;
   logic [CW-1:0]         w_count_nxt;
   logic [CW-1:0]         w_free_nxt;
   logic                  w_full_nxt;
   logic                  w_empty_nxt;
   logic                  w_almost_full_nxt;
   logic                  w_almost_empty_nxt;

   // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
   assign w_rd_accept = read_enable & ~r_empty;
   assign w_wr_accept = write_enable & (~r_full | w_rd_accept);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_accept, w_rd_accept})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_free_nxt         = DEPTH_C - w_count_nxt;
      w_full_nxt         = (w_count_nxt == DEPTH_C);
      w_empty_nxt        = (w_count_nxt == CW'(0));
      w_almost_full_nxt  = (32'(w_free_nxt) <= AF_TH);
      w_almost_empty_nxt = (32'(w_count_nxt) <= AE_TH);
   end

   // Storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (w_wr_accept && !reset) begin
         r_mem[r_wr_ptr] <= FIFO_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_valid        <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= AF_RST;
         r_almost_empty <= 1'b1;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_rd_accept) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_valid        <= w_rd_accept;
         r_count        <= w_count_nxt;
         r_full         <= w_full_nxt;
         r_empty        <= w_empty_nxt;
         r_almost_full  <= w_almost_full_nxt;
         r_almost_empty <= w_almost_empty_nxt;
      end
   end

`ifdef FIFO_ERROR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error indications, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write_enable && !w_wr_accept) begin
            r_overflow <= 1'b1;
         end
         if (read_enable && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign FIFO_overflow  = r_overflow;
   assign FIFO_underflow = r_underflow;
`endif

   assign FIFO_data_out     = r_data_out;
   assign FIFO_valid        = r_valid;
   assign FIFO_full         = r_full;
   assign FIFO_empty        = r_empty;
   assign FIFO_almost_full  = r_almost_full;
   assign FIFO_almost_empty = r_almost_empty;
   assign FIFO_count        = r_count;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param with default parameters (DEPTH=256, thresholds 3).
// Error-flag checks are compiled in when FIFO_ERROR_FLAGS_EN is defined.
module tb_fifo_param;

   logic        clk;
   logic        reset;
   logic        write_enable;
   logic [11:0] FIFO_data_in;
   logic        read_enable;
   logic [11:0] FIFO_data_out;
   logic        FIFO_valid;
   logic        FIFO_full;
   logic        FIFO_empty;
   logic        FIFO_almost_full;
   logic        FIFO_almost_empty;
   logic [8:0]  FIFO_count;
`ifdef FIFO_ERROR_FLAGS_EN
   logic        FIFO_overflow;
   logic        FIFO_underflow;
`endif

   int n_vec = 0;
   int n_err = 0;

   fifo_param dut (
      .clk               (clk),
      .reset             (reset),
      .write_enable      (write_enable),
      .FIFO_data_in      (FIFO_data_in),
      .read_enable       (read_enable),
      .FIFO_data_out     (FIFO_data_out),
      .FIFO_valid        (FIFO_valid),
      .FIFO_full         (FIFO_full),
      .FIFO_empty        (FIFO_empty),
      .FIFO_almost_full  (FIFO_almost_full),
      .FIFO_almost_empty (FIFO_almost_empty),
`ifdef FIFO_ERROR_FLAGS_EN
      .FIFO_overflow     (FIFO_overflow),
      .FIFO_underflow    (FIFO_underflow),
`endif
      .FIFO_count        (FIFO_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      FIFO_data_in = 12'h000;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      repeat (3) cycle();
      n_vec++;
      if (FIFO_empty !== 1'b1 || FIFO_almost_empty !== 1'b1 || FIFO_full !== 1'b0 ||
          FIFO_almost_full !== 1'b0 || FIFO_count !== 9'd0 || FIFO_valid !== 1'b0 ||
          FIFO_data_out !== 12'h000) begin
         n_err++;
         $display("FAIL reset_state: empty=%b ae=%b full=%b af=%b count=%0d valid=%b dout=%h, required 1 1 0 0 0 0 000",
                  FIFO_empty, FIFO_almost_empty, FIFO_full, FIFO_almost_full, FIFO_count, FIFO_valid, FIFO_data_out);
      end
`ifdef FIFO_ERROR_FLAGS_EN
      n_vec++;
      if (FIFO_overflow !== 1'b0 || FIFO_underflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_errflags: ovf=%b unf=%b, required 0 0", FIFO_overflow, FIFO_underflow);
      end
`endif
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 256; i++) begin
         write_enable = 1'b1;
         FIFO_data_in = 12'(i);
         cycle();
         n_vec++;
         if (FIFO_count !== 9'(i) || FIFO_full !== (i == 256) || FIFO_almost_full !== (i >= 253) ||
             FIFO_empty !== 1'b0 || FIFO_almost_empty !== (i <= 3)) begin
            n_err++;
            $display("FAIL fill_%0d: count=%0d full=%b af=%b empty=%b ae=%b, required count=%0d full=%b af=%b empty=0 ae=%b",
                     i, FIFO_count, FIFO_full, FIFO_almost_full, FIFO_empty, FIFO_almost_empty,
                     i, (i == 256), (i >= 253), (i <= 3));
         end
      end
      FIFO_data_in = 12'h101;
      cycle();
      idle_inputs();
      n_vec++;
      if (FIFO_count !== 9'd256 || FIFO_full !== 1'b1 || FIFO_valid !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_drop: count=%0d full=%b valid=%b, required 256 1 0", FIFO_count, FIFO_full, FIFO_valid);
      end
`ifdef FIFO_ERROR_FLAGS_EN
      n_vec++;
      if (FIFO_overflow !== 1'b1 || FIFO_underflow !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_flag: ovf=%b unf=%b, required 1 0", FIFO_overflow, FIFO_underflow);
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 256; i++) begin
         read_enable = 1'b1;
         cycle();
         n_vec++;
         if (FIFO_data_out !== 12'(i) || FIFO_valid !== 1'b1 || FIFO_count !== 9'(256 - i) ||
             FIFO_empty !== (i == 256) || FIFO_almost_empty !== ((256 - i) <= 3) || FIFO_full !== 1'b0) begin
            n_err++;
            $display("FAIL drain_%0d: dout=%h valid=%b count=%0d empty=%b ae=%b full=%b, required dout=%h valid=1 count=%0d empty=%b ae=%b full=0",
                     i, FIFO_data_out, FIFO_valid, FIFO_count, FIFO_empty, FIFO_almost_empty, FIFO_full,
                     12'(i), 256 - i, (i == 256), ((256 - i) <= 3));
         end
      end
      cycle();
      idle_inputs();
      n_vec++;
      if (FIFO_valid !== 1'b0 || FIFO_data_out !== 12'h100 || FIFO_count !== 9'd0 || FIFO_empty !== 1'b1) begin
         n_err++;
         $display("FAIL underflow_read: valid=%b dout=%h count=%0d empty=%b, required 0 100 0 1",
                  FIFO_valid, FIFO_data_out, FIFO_count, FIFO_empty);
      end
`ifdef FIFO_ERROR_FLAGS_EN
      n_vec++;
      if (FIFO_underflow !== 1'b1) begin
         n_err++;
         $display("FAIL underflow_flag: unf=%b, required 1", FIFO_underflow);
      end
`endif
   endtask

   task automatic push_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         write_enable = 1'b1;
         FIFO_data_in = 12'(base + i);
         cycle();
      end
      idle_inputs();
   endtask

   task automatic pop_check(input int n, input int base, input string tag);
      for (int i = 0; i < n; i++) begin
         read_enable = 1'b1;
         cycle();
         n_vec++;
         if (FIFO_data_out !== 12'(base + i) || FIFO_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_%0d: dout=%h valid=%b, required %h 1", tag, i, FIFO_data_out, FIFO_valid, 12'(base + i));
         end
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      push_n(200, 0);
      n_vec++;
      if (FIFO_count !== 9'd200) begin
         n_err++;
         $display("FAIL wrap_count200: count=%0d, required 200", FIFO_count);
      end
      pop_check(200, 0, "wrap_a");
      push_n(100, 0);
      pop_check(100, 0, "wrap_b");
      cycle();
      n_vec++;
      if (FIFO_count !== 9'd0 || FIFO_empty !== 1'b1 || FIFO_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_end: count=%0d empty=%b valid=%b, required 0 1 0", FIFO_count, FIFO_empty, FIFO_valid);
      end
   endtask

   task automatic test_simultaneous();
      push_n(256, 12'h200);
      write_enable = 1'b1;
      read_enable  = 1'b1;
      FIFO_data_in = 12'hABC;
      cycle();
      idle_inputs();
      n_vec++;
      if (FIFO_count !== 9'd256 || FIFO_full !== 1'b1 || FIFO_data_out !== 12'h200 || FIFO_valid !== 1'b1) begin
         n_err++;
         $display("FAIL full_rw: count=%0d full=%b dout=%h valid=%b, required 256 1 200 1",
                  FIFO_count, FIFO_full, FIFO_data_out, FIFO_valid);
      end
      pop_check(255, 12'h201, "full_rw_tail");
      pop_check(1, 12'hABC, "full_rw_new");
      write_enable = 1'b1;
      read_enable  = 1'b1;
      FIFO_data_in = 12'h555;
      cycle();
      idle_inputs();
      n_vec++;
      if (FIFO_count !== 9'd1 || FIFO_valid !== 1'b0 || FIFO_empty !== 1'b0 || FIFO_almost_empty !== 1'b1) begin
         n_err++;
         $display("FAIL empty_rw: count=%0d valid=%b empty=%b ae=%b, required 1 0 0 1",
                  FIFO_count, FIFO_valid, FIFO_empty, FIFO_almost_empty);
      end
      pop_check(1, 12'h555, "empty_rw_word");
   endtask

   task automatic test_reset_midop();
      push_n(50, 12'h300);
      write_enable = 1'b1;
      read_enable  = 1'b1;
      FIFO_data_in = 12'h777;
      reset        = 1'b1;
      cycle();
      reset = 1'b0;
      idle_inputs();
      n_vec++;
      if (FIFO_count !== 9'd0 || FIFO_empty !== 1'b1 || FIFO_valid !== 1'b0 || FIFO_full !== 1'b0 ||
          FIFO_data_out !== 12'h000 || FIFO_almost_empty !== 1'b1) begin
         n_err++;
         $display("FAIL reset_midop: count=%0d empty=%b valid=%b full=%b dout=%h ae=%b, required 0 1 0 0 000 1",
                  FIFO_count, FIFO_empty, FIFO_valid, FIFO_full, FIFO_data_out, FIFO_almost_empty);
      end
`ifdef FIFO_ERROR_FLAGS_EN
      n_vec++;
      if (FIFO_overflow !== 1'b0 || FIFO_underflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_midop_errflags: ovf=%b unf=%b, required 0 0", FIFO_overflow, FIFO_underflow);
      end
`endif
      push_n(1, 12'h123);
      pop_check(1, 12'h123, "post_reset");
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
